// File: rtl/uart_bus_master.sv
// Debug bridge: turns UART command bytes into 6-bit peripheral bus reads/writes and
// answers each command with ACK, NAK or the read value through the UART transmitter.
module uart_bus_master #(
  parameter int         TIMEOUT_CYCLES = 27000000,
  parameter logic [7:0] ACK            = 8'h06,
  parameter logic [7:0] NAK            = 8'h15
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_ready_clear,
  output logic [7:0] tx_data,
  output logic       tx_strobe,
  input  logic       tx_busy,
  output logic [5:0] address,
  output logic [7:0] data_out,
  output logic       write_enable,
  output logic       enable,
  input  logic [7:0] data_in,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, GET_DATA, WRITE, READ_1, READ_2, SEND, SEND_WAIT
  } state_t;

  localparam logic [24:0] TIMER_LAST = 25'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [24:0] timer;
  logic        armed;
  logic        take;

  // A byte is taken only once rx_ready has been seen low since the previous take.
  assign take = rx_ready && armed && (state == IDLE || state == GET_DATA);

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= '0;
      armed          <= 1'b0;
      rx_ready_clear <= 1'b0;
      tx_data        <= '0;
      tx_strobe      <= 1'b0;
      address        <= '0;
      data_out       <= '0;
      write_enable   <= 1'b0;
      enable         <= 1'b0;
      busy           <= 1'b0;
    end else begin
      rx_ready_clear <= take;
      if (take) armed <= 1'b0;
      else if (!rx_ready) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (take) begin
            busy <= 1'b1;
            if (rx_data[6]) begin
              tx_data   <= NAK;
              tx_strobe <= 1'b1;
              state     <= SEND;
            end else if (rx_data[7]) begin
              address <= rx_data[5:0];
              timer   <= '0;
              state   <= GET_DATA;
            end else begin
              address <= rx_data[5:0];
              enable  <= 1'b1;
              state   <= READ_1;
            end
          end
        end
        GET_DATA: begin
          // An arriving byte beats a timeout falling on the same cycle.
          if (take) begin
            data_out     <= rx_data;
            write_enable <= 1'b1;
            state        <= WRITE;
          end else if (timer == TIMER_LAST) begin
            tx_data   <= NAK;
            tx_strobe <= 1'b1;
            state     <= SEND;
          end else if (timer != '1) begin
            timer <= timer + 25'd1;
          end
        end
        WRITE: begin
          write_enable <= 1'b0;
          tx_data      <= ACK;
          tx_strobe    <= 1'b1;
          state        <= SEND;
        end
        READ_1: state <= READ_2;
        READ_2: begin
          enable    <= 1'b0;
          tx_data   <= data_in;
          tx_strobe <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (tx_busy) begin
            tx_strobe <= 1'b0;
            state     <= SEND_WAIT;
          end
        end
        SEND_WAIT: begin
          if (!tx_busy) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with small UART receiver/transmitter models.
module tb_uart_bus_master;

  logic       raw_clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ready_clear;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       tx_busy;
  logic [5:0] address;
  logic [7:0] data_out;
  logic       write_enable;
  logic       enable;
  logic [7:0] data_in;
  logic       busy;

  uart_bus_master #(.TIMEOUT_CYCLES(100), .ACK(8'h06), .NAK(8'h15)) dut (
    .raw_clk(raw_clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_ready_clear(rx_ready_clear), .tx_data(tx_data), .tx_strobe(tx_strobe),
    .tx_busy(tx_busy), .address(address), .data_out(data_out),
    .write_enable(write_enable), .enable(enable), .data_in(data_in), .busy(busy)
  );

  always #5 raw_clk = ~raw_clk;

  int total = 0;
  int bad   = 0;

  // Bus / receive-handshake monitor, sampled just after each rising edge.
  int         we_cnt, en_cnt, overlap_cnt, clr_run, clr_run_max, clr_pulses;
  logic [5:0] we_addr;
  logic [7:0] we_dat;
  always @(posedge raw_clk) begin
    #1;
    if (write_enable) begin
      we_cnt++;
      we_addr = address;
      we_dat  = data_out;
    end
    if (enable) en_cnt++;
    if (write_enable && enable) overlap_cnt++;
    if (rx_ready_clear) begin
      if (clr_run == 0) clr_pulses++;
      clr_run++;
      if (clr_run > clr_run_max) clr_run_max = clr_run;
      rx_ready = 1'b0;
    end else begin
      clr_run = 0;
    end
  end

  // Transmitter model: busy_delay cycles after a strobe it raises tx_busy for busy_len cycles.
  int         tx_cnt = 0;
  int         busy_delay = 1;
  int         busy_len = 3;
  int         strobe_drop = 0;
  int         strobe_late = 0;
  logic [7:0] tx_last;
  logic [7:0] tx_log [16];
  always begin
    @(posedge raw_clk);
    #2;
    if (tx_strobe && !tx_busy && !reset) begin
      tx_last = tx_data;
      tx_log[tx_cnt % 16] = tx_data;
      tx_cnt++;
      repeat (busy_delay) begin
        @(posedge raw_clk);
        #2;
        if (!tx_strobe) strobe_drop++;
      end
      tx_busy = 1'b1;
      @(posedge raw_clk);
      #2;
      if (tx_strobe) strobe_late++;
      repeat (busy_len - 1) @(posedge raw_clk);
      #2;
      tx_busy = 1'b0;
    end
  end

  task automatic clear_mon();
    we_cnt = 0; en_cnt = 0; overlap_cnt = 0;
    clr_run_max = 0; clr_pulses = 0; strobe_drop = 0; strobe_late = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    while (rx_ready && k < 2000) begin
      @(negedge raw_clk);
      k++;
    end
    total++;
    if (rx_ready) begin
      bad++;
      $display("FAIL rx_consume byte=%h still pending after %0d cycles", b, k);
    end
    @(negedge raw_clk);
    rx_data  = b;
    rx_ready = 1'b1;
  endtask

  task automatic wait_done(input int n, input string name);
    int k = 0;
    while (!(tx_cnt >= n && !busy && !tx_busy) && k < 2000) begin
      @(negedge raw_clk);
      k++;
    end
    total++;
    if (k >= 2000) begin
      bad++;
      $display("FAIL %s_done got tx_cnt=%0d busy=%b want tx_cnt=%0d busy=0", name, tx_cnt, busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge raw_clk);
    #1;
    total++;
    if ({rx_ready_clear, tx_data, tx_strobe, address, data_out, write_enable, enable, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got txd=%h stb=%b adr=%h dout=%h we=%b en=%b busy=%b clr=%b want all 0",
               tx_data, tx_strobe, address, data_out, write_enable, enable, busy, rx_ready_clear);
    end
    @(negedge raw_clk);
    reset = 1'b0;
    repeat (2) @(negedge raw_clk);
  endtask

  task automatic test_write();
    int base = tx_cnt;
    clear_mon();
    send_byte(8'hA6);
    @(posedge raw_clk); #1;
    total++;
    if (busy !== 1'b1 || rx_ready_clear !== 1'b1) begin
      bad++; $display("FAIL wr_cmd_accept got busy=%b clr=%b want 1 1", busy, rx_ready_clear);
    end
    repeat (3) @(negedge raw_clk);
    send_byte(8'h1E);
    @(posedge raw_clk); #1;
    total++;
    if (write_enable !== 1'b1 || address !== 6'h26 || data_out !== 8'h1E) begin
      bad++; $display("FAIL wr_strobe got we=%b adr=%h dout=%h want 1 26 1e", write_enable, address, data_out);
    end
    @(posedge raw_clk); #1;
    total++;
    if (write_enable !== 1'b0 || tx_strobe !== 1'b1 || address !== 6'h26 || data_out !== 8'h1E) begin
      bad++; $display("FAIL wr_next got we=%b stb=%b adr=%h dout=%h want 0 1 26 1e",
                      write_enable, tx_strobe, address, data_out);
    end
    wait_done(base + 1, "wr");
    total++;
    if (we_cnt !== 1 || we_addr !== 6'h26 || we_dat !== 8'h1E || en_cnt !== 0) begin
      bad++; $display("FAIL wr_bus got we_cnt=%0d adr=%h dat=%h en_cnt=%0d want 1 26 1e 0",
                      we_cnt, we_addr, we_dat, en_cnt);
    end
    total++;
    if (tx_last !== 8'h06 || tx_cnt !== base + 1) begin
      bad++; $display("FAIL wr_ack got tx=%h cnt=%0d want 06 %0d", tx_last, tx_cnt, base + 1);
    end
  endtask

  task automatic test_read();
    int base = tx_cnt;
    clear_mon();
    data_in = 8'h00;
    send_byte(8'h13);
    @(posedge raw_clk); #1;
    total++;
    if (enable !== 1'b1 || address !== 6'h13 || busy !== 1'b1) begin
      bad++; $display("FAIL rd_first got en=%b adr=%h busy=%b want 1 13 1", enable, address, busy);
    end
    data_in = 8'h5A;
    @(posedge raw_clk); #1;
    total++;
    if (enable !== 1'b1 || tx_strobe !== 1'b0) begin
      bad++; $display("FAIL rd_second got en=%b stb=%b want 1 0", enable, tx_strobe);
    end
    @(posedge raw_clk); #1;
    total++;
    if (enable !== 1'b0 || tx_strobe !== 1'b1 || tx_data !== 8'h5A) begin
      bad++; $display("FAIL rd_capture got en=%b stb=%b txd=%h want 0 1 5a", enable, tx_strobe, tx_data);
    end
    wait_done(base + 1, "rd");
    total++;
    if (en_cnt !== 2 || we_cnt !== 0 || tx_last !== 8'h5A) begin
      bad++; $display("FAIL rd_result got en_cnt=%0d we_cnt=%0d tx=%h want 2 0 5a", en_cnt, we_cnt, tx_last);
    end
  endtask

  task automatic test_malformed();
    int base = tx_cnt;
    clear_mon();
    send_byte(8'h40);
    wait_done(base + 1, "bad_cmd");
    total++;
    if (tx_last !== 8'h15 || we_cnt !== 0 || en_cnt !== 0) begin
      bad++; $display("FAIL bad_cmd got tx=%h we_cnt=%0d en_cnt=%0d want 15 0 0", tx_last, we_cnt, en_cnt);
    end
  endtask

  task automatic test_timeout();
    int base = tx_cnt;
    int k = 0;
    clear_mon();
    send_byte(8'h88);
    @(posedge raw_clk); #1;
    while (!tx_strobe && k < 300) begin
      @(posedge raw_clk); #1;
      k++;
    end
    total++;
    if (k !== 100) begin
      bad++; $display("FAIL timeout_cycles got %0d want 100", k);
    end
    wait_done(base + 1, "timeout");
    total++;
    if (tx_last !== 8'h15 || we_cnt !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_result got tx=%h we_cnt=%0d busy=%b want 15 0 0", tx_last, we_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    int base = tx_cnt;
    clear_mon();
    busy_delay = 3;
    busy_len   = 50;
    data_in    = 8'hC3;
    send_byte(8'h85);
    send_byte(8'h3C);
    send_byte(8'h13);
    wait_done(base + 2, "b2b");
    total++;
    if (tx_log[base % 16] !== 8'h06 || tx_log[(base + 1) % 16] !== 8'hC3) begin
      bad++; $display("FAIL b2b_responses got %h %h want 06 c3", tx_log[base % 16], tx_log[(base + 1) % 16]);
    end
    total++;
    if (strobe_drop !== 0 || strobe_late !== 0) begin
      bad++; $display("FAIL b2b_strobe_hold got early_drops=%0d late_drops=%0d want 0 0", strobe_drop, strobe_late);
    end
    total++;
    if (clr_run_max !== 1 || clr_pulses !== 3) begin
      bad++; $display("FAIL b2b_clear got width=%0d pulses=%0d want 1 3", clr_run_max, clr_pulses);
    end
    total++;
    if (we_cnt !== 1 || we_addr !== 6'h05 || we_dat !== 8'h3C || en_cnt !== 2 || overlap_cnt !== 0) begin
      bad++; $display("FAIL b2b_bus got we=%0d adr=%h dat=%h en=%0d ovl=%0d want 1 05 3c 2 0",
                      we_cnt, we_addr, we_dat, en_cnt, overlap_cnt);
    end
    busy_delay = 1;
    busy_len   = 3;
  endtask

  task automatic test_reset_mid_read();
    int base = tx_cnt;
    clear_mon();
    send_byte(8'h21);
    @(posedge raw_clk); #1;
    total++;
    if (enable !== 1'b1) begin
      bad++; $display("FAIL rst_rd_enter got en=%b want 1", enable);
    end
    @(negedge raw_clk);
    reset = 1'b1;
    @(posedge raw_clk); #1;
    total++;
    if ({rx_ready_clear, tx_data, tx_strobe, address, data_out, write_enable, enable, busy} !== '0) begin
      bad++; $display("FAIL rst_rd_outputs got txd=%h stb=%b adr=%h we=%b en=%b busy=%b want all 0",
                      tx_data, tx_strobe, address, write_enable, enable, busy);
    end
    @(negedge raw_clk);
    reset = 1'b0;
    repeat (10) @(negedge raw_clk);
    total++;
    if (tx_cnt !== base || we_cnt !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_rd_quiet got tx_cnt=%0d we_cnt=%0d busy=%b want %0d 0 0",
                      tx_cnt, we_cnt, busy, base);
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    tx_busy  = 1'b0;
    data_in  = 8'h00;
    clr_run  = 0;
    clear_mon();
    test_reset();
    test_write();
    test_read();
    test_malformed();
    test_timeout();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
